pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Sequencing controller for the program counter register in the single-cycle MIPS core. It computes PC_next each cycle. The pc register loads unconditionally every CLK, so the controller holds the PC by driving PC_next = PC_curr. It fetches over a req/ack instruction-memory handshake and commits exactly one instruction per EXEC cycle. It also handles halt/run/single-step control and a minimal exception path.

Parameters:
WL, 32, datapath word length
EXC_VEC, 32'h00000180, exception vector loaded into PC on illegal op or misaligned target

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
PC_curr  in  WL  current PC from pc register
PC_next  out  WL  next PC to pc register
START  in  1  leave IDLE/HALTED and run freely
STEP  in  1  from HALTED, execute exactly one instruction
HALT_REQ  in  1  decode of break/syscall, valid in EXEC
IM_REQ  out  1  instruction fetch request, address = PC_curr
IM_ACK  in  1  instruction word valid this cycle
Branch  in  1  beq-class decode
Zero  in  1  ALU zero flag
Jump  in  1  j/jal decode
JR  in  1  jr decode
SignImm  in  WL  sign-extended immediate
JIdx  in  26  instr[25:0]
RegTarget  in  WL  rs value for jr
Illegal  in  1  undefined opcode decode
INSTR_VALID  out  1  commit strobe; gates regfile/dmem write enables
HALTED  out  1  state == HALTED
EPC  out  WL  PC of faulting instruction
CAUSE  out  2  0 none, 1 illegal op, 2 misaligned target
INSTR_CNT  out  32  committed-instruction counter

Behaviour:
- Reset (async, RST=1): state=IDLE; all outputs zero. EPC=0, CAUSE=0, INSTR_CNT=0. PC_next=PC_curr (comb). IM_REQ drops immediately, including mid-FETCH.
- States:
  - IDLE: START -> FETCH.
  - FETCH: IM_REQ=1. IM_ACK -> EXEC, otherwise stay. ACK outside FETCH is ignored.
  - EXEC: one cycle, INSTR_VALID=1, PC updates at end of cycle. Next state is FETCH, or HALTED if HALT_REQ or step_mode.
  - HALTED: START -> FETCH with step_mode=0. STEP -> FETCH with step_mode=1. START wins if both are high.
- PC_next = PC_curr in every state except EXEC.
- pc4 = PC_curr + 4, modulo 2^WL. 0xFFFFFFFC wraps to 0.
- EXEC next-PC priority, highest first:
  1. Illegal: EXC_VEC, EPC<=PC_curr, CAUSE<=1.
  2. JR with RegTarget[1:0]!=0: EXC_VEC, EPC<=PC_curr, CAUSE<=2.
  3. JR: RegTarget.
  4. Jump: {pc4[WL-1:28], JIdx, 2'b00}.
  5. Branch&Zero: pc4 + (SignImm<<2), modulo 2^WL.
  6. Otherwise pc4.
- An exception instruction still asserts INSTR_VALID. Register writes must be suppressed in the datapath using CAUSE update visibility next cycle. This is a single-cycle core, so the datapath instead gates with Illegal directly.
- INSTR_CNT increments on every EXEC cycle, exceptions included, and wraps at 2^32.
- HALT_REQ in EXEC: PC still advances normally, then HALTED.
- EPC/CAUSE hold until the next exception or reset. Not cleared by START.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ACK, then EXEC).

Test Plan:
- Reset then START, IM_ACK tied 1 -> IM_REQ high every other cycle. PC sequence 0,4,8,12. INSTR_CNT=3 after three EXECs.
- IM_ACK delayed 3 cycles in FETCH -> IM_REQ held 4 cycles, PC_next==PC_curr throughout. Single INSTR_VALID pulse.
- PC=0x40, Branch=1, Zero=1, SignImm=-2 -> PC becomes 0x3C. Same with Zero=0 -> 0x44.
- PC=0x40, Jump=1 and Branch&Zero both high, JIdx=0x100 -> PC becomes 0x400 (jump wins). JR with RegTarget=0x1002 -> PC=0x180, CAUSE=2, EPC=0x40.
- HALT_REQ at PC=0x10 -> HALTED=1, PC=0x14 stable for 20 cycles. STEP pulse -> exactly one EXEC, PC=0x18, back to HALTED.
- RST asserted mid-FETCH at PC=0x20 -> IM_REQ low same cycle, state IDLE, INSTR_CNT=0. PC_curr=0 via pc reset. PC=0xFFFFFFFC plain instruction -> wraps to 0.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: instruction-memory fetch handshake.
//   IM_REQ : fetch request from the controller, address is the current PC
//   IM_ACK : instruction word valid this cycle, from instruction memory
interface pc_fetch_ctrl_if;
    logic IM_REQ;
    logic IM_ACK;
    modport master (output IM_REQ, input IM_ACK);
    modport slave  (input IM_REQ, output IM_ACK);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter sequencing controller for the single-cycle MIPS core.
//   CLK, RST            : clock (rising edge), asynchronous active-high reset
//   PC_curr / PC_next   : current PC in, next PC out (pc register loads every cycle)
//   START, STEP         : run freely / execute one instruction from HALTED
//   HALT_REQ            : break/syscall decode, sampled in EXEC
//   im                  : IM_REQ/IM_ACK fetch handshake
//   Branch, Zero, Jump, JR, SignImm, JIdx, RegTarget, Illegal : decode/datapath inputs
//   INSTR_VALID         : commit strobe (one cycle per executed instruction)
//   HALTED              : controller is halted
//   EPC, CAUSE          : faulting PC and cause (1 illegal op, 2 misaligned target)
//   INSTR_CNT           : committed-instruction counter
module pc_fetch_ctrl #(
    parameter int WL = 32,
    parameter logic [WL-1:0] EXC_VEC = 'h180
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [WL-1:0]  PC_curr,
    output logic [WL-1:0]  PC_next,
    input  logic           START,
    input  logic           STEP,
    input  logic           HALT_REQ,
    pc_fetch_ctrl_if.master im,
    input  logic           Branch,
    input  logic           Zero,
    input  logic           Jump,
    input  logic           JR,
    input  logic [WL-1:0]  SignImm,
    input  logic [25:0]    JIdx,
    input  logic [WL-1:0]  RegTarget,
    input  logic           Illegal,
    output logic           INSTR_VALID,
    output logic           HALTED,
    output logic [WL-1:0]  EPC,
    output logic [1:0]     CAUSE,
    output logic [31:0]    INSTR_CNT
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          step_q, step_d;
    logic [WL-1:0] epc_q, epc_d;
    logic [1:0]    cause_q, cause_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [WL-1:0] pc4;

    assign pc4 = PC_curr + WL'(4);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        PC_next = PC_curr;
        case (state_q)
            S_IDLE: if (START) begin
                state_d = S_FETCH;
                step_d  = 1'b0;
            end
            S_FETCH: if (im.IM_ACK) state_d = S_EXEC;
            S_EXEC: begin
                // step_mode sends every instruction straight back to HALTED
                state_d = (HALT_REQ || step_q) ? S_HALTED : S_FETCH;
                cnt_d   = cnt_q + 32'd1;
                if (Illegal) begin
                    PC_next = EXC_VEC;
                    epc_d   = PC_curr;
                    cause_d = 2'd1;
                end else if (JR && RegTarget[1:0] != 2'b00) begin
                    PC_next = EXC_VEC;
                    epc_d   = PC_curr;
                    cause_d = 2'd2;
                end else if (JR)
                    PC_next = RegTarget;
                else if (Jump)
                    PC_next = {pc4[WL-1:28], JIdx, 2'b00};
                else if (Branch && Zero)
                    PC_next = pc4 + (SignImm << 2);
                else
                    PC_next = pc4;
            end
            default: if (START) begin
                state_d = S_FETCH;
                step_d  = 1'b0;
            end else if (STEP) begin
                state_d = S_FETCH;
                step_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            step_q  <= 1'b0;
            epc_q   <= '0;
            cause_q <= 2'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // state_q clears asynchronously, so IM_REQ falls in the same cycle RST rises
    assign im.IM_REQ   = (state_q == S_FETCH);
    assign INSTR_VALID = (state_q == S_EXEC);
    assign HALTED      = (state_q == S_HALTED);
    assign EPC         = epc_q;
    assign CAUSE       = cause_q;
    assign INSTR_CNT   = cnt_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed self-checking bench for pc_fetch_ctrl with a modelled pc register.
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc, pc_next;
    logic        start = 0, step = 0, halt_req = 0;
    logic        branch = 0, zero = 0, jump = 0, jr = 0, illegal = 0;
    logic [31:0] sign_imm = 0, reg_target = 0;
    logic [25:0] jidx = 0;
    logic        instr_valid, halted;
    logic [31:0] epc, instr_cnt;
    logic [1:0]  cause;
    logic        ld = 0;
    logic [31:0] ld_val = 0;
    int          n_cmp = 0, n_bad = 0;

    pc_fetch_ctrl_if im_if ();

    pc_fetch_ctrl dut (
        .CLK(clk), .RST(rst), .PC_curr(pc), .PC_next(pc_next),
        .START(start), .STEP(step), .HALT_REQ(halt_req), .im(im_if),
        .Branch(branch), .Zero(zero), .Jump(jump), .JR(jr),
        .SignImm(sign_imm), .JIdx(jidx), .RegTarget(reg_target), .Illegal(illegal),
        .INSTR_VALID(instr_valid), .HALTED(halted), .EPC(epc), .CAUSE(cause),
        .INSTR_CNT(instr_cnt)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= 32'd0;
        else     pc <= ld ? ld_val : pc_next;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // from FETCH with IM_ACK low: force pc, then run one fetch+exec; returns mid-EXEC
    task automatic exec_at(input logic [31:0] a);
        ld = 1; ld_val = a;
        cyc();
        ld = 0; im_if.IM_ACK = 1;
        cyc();
        im_if.IM_ACK = 0;
        #1;
    endtask

    initial begin
        im_if.IM_ACK = 0;
        repeat (2) cyc();
        chk("rst_req", {31'd0, im_if.IM_REQ}, 0);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_epc", epc, 0);
        chk("rst_cause", {30'd0, cause}, 0);
        chk("rst_cnt", instr_cnt, 0);
        chk("rst_pcnext", pc_next, 0);
        rst = 0;
        cyc();
        chk("idle_req", {31'd0, im_if.IM_REQ}, 0);
        start = 1; im_if.IM_ACK = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            chk("run_fetch_req", {31'd0, im_if.IM_REQ}, 1);
            chk("run_fetch_pc", pc, 32'(4 * i));
            chk("run_fetch_hold", pc_next, 32'(4 * i));
            cyc();
            chk("run_exec_valid", {31'd0, instr_valid}, 1);
            chk("run_exec_req", {31'd0, im_if.IM_REQ}, 0);
            chk("run_exec_next", pc_next, 32'(4 * i + 4));
            cyc();
        end
        im_if.IM_ACK = 0;
        chk("run_pc12", pc, 32'd12);
        chk("run_cnt3", instr_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'd0, im_if.IM_REQ}, 1);
            chk("wait_hold", pc_next, 32'd12);
            chk("wait_valid", {31'd0, instr_valid}, 0);
            cyc();
        end
        im_if.IM_ACK = 1;
        #1 chk("wait_req4", {31'd0, im_if.IM_REQ}, 1);
        cyc();
        im_if.IM_ACK = 0;
        chk("wait_exec", {31'd0, instr_valid}, 1);
        cyc();
        chk("wait_single", {31'd0, instr_valid}, 0);
        chk("wait_pc16", pc, 32'd16);
        branch = 1; zero = 1; sign_imm = 32'hFFFF_FFFE;
        exec_at(32'h40);
        chk("beq_taken", pc_next, 32'h3C);
        cyc();
        chk("beq_taken_pc", pc, 32'h3C);
        zero = 0;
        exec_at(32'h40);
        chk("beq_not", pc_next, 32'h44);
        cyc();
        zero = 1; jump = 1; jidx = 26'h100;
        exec_at(32'h40);
        chk("jump_wins", pc_next, 32'h400);
        cyc();
        chk("jump_pc", pc, 32'h400);
        branch = 0; zero = 0; jump = 0; jr = 1; reg_target = 32'h1002;
        exec_at(32'h40);
        chk("jr_mis_next", pc_next, 32'h180);
        chk("jr_mis_valid", {31'd0, instr_valid}, 1);
        cyc();
        chk("jr_mis_pc", pc, 32'h180);
        chk("jr_mis_cause", {30'd0, cause}, 2);
        chk("jr_mis_epc", epc, 32'h40);
        illegal = 1;
        exec_at(32'h80);
        chk("ill_next", pc_next, 32'h180);
        cyc();
        chk("ill_cause", {30'd0, cause}, 1);
        chk("ill_epc", epc, 32'h80);
        illegal = 0; reg_target = 32'h2000;
        exec_at(32'h90);
        chk("jr_ok", pc_next, 32'h2000);
        cyc();
        chk("jr_ok_cause", {30'd0, cause}, 1);
        chk("jr_ok_epc", epc, 32'h80);
        chk("cnt10", instr_cnt, 10);
        jr = 0; halt_req = 1;
        exec_at(32'h10);
        chk("halt_next", pc_next, 32'h14);
        cyc();
        halt_req = 0; im_if.IM_ACK = 1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_state", {31'd0, halted}, 1);
            chk("halt_pc", pc, 32'h14);
            chk("halt_req_low", {31'd0, im_if.IM_REQ}, 0);
            cyc();
        end
        im_if.IM_ACK = 0;
        chk("halt_cnt", instr_cnt, 11);
        step = 1;
        cyc();
        step = 0;
        chk("step_fetch", {31'd0, im_if.IM_REQ}, 1);
        chk("step_unhalt", {31'd0, halted}, 0);
        im_if.IM_ACK = 1;
        cyc();
        im_if.IM_ACK = 0;
        chk("step_exec", {31'd0, instr_valid}, 1);
        chk("step_next", pc_next, 32'h18);
        cyc();
        chk("step_halted", {31'd0, halted}, 1);
        cyc();
        chk("step_pc", pc, 32'h18);
        chk("step_cnt", instr_cnt, 12);
        start = 1; step = 1;
        cyc();
        start = 0; step = 0; im_if.IM_ACK = 1;
        chk("both_fetch", {31'd0, im_if.IM_REQ}, 1);
        cyc();
        im_if.IM_ACK = 0;
        cyc();
        chk("both_free_run", {31'd0, im_if.IM_REQ}, 1);
        chk("both_not_halt", {31'd0, halted}, 0);
        chk("both_pc", pc, 32'h1C);
        exec_at(32'hFFFF_FFFC);
        chk("wrap_next", pc_next, 32'd0);
        cyc();
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_cnt", instr_cnt, 14);
        ld = 1; ld_val = 32'h20;
        cyc();
        ld = 0;
        chk("mid_fetch_req", {31'd0, im_if.IM_REQ}, 1);
        chk("mid_fetch_pc", pc, 32'h20);
        rst = 1;
        #1;
        chk("arst_req", {31'd0, im_if.IM_REQ}, 0);
        chk("arst_cnt", instr_cnt, 0);
        chk("arst_cause", {30'd0, cause}, 0);
        chk("arst_epc", epc, 0);
        chk("arst_pc", pc, 0);
        chk("arst_next", pc_next, 0);
        cyc();
        rst = 0;
        cyc();
        chk("arst_idle", {31'd0, im_if.IM_REQ}, 0);
        chk("arst_idle_valid", {31'd0, instr_valid}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
